// File: rtl/proc_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_feeder_pkg : shared constants for the processor instruction feeder
// Revision: 1.0
// ---------------------------------------------------------------------------
package proc_feeder_pkg;

  localparam int DEPTH  = 8;
  localparam int TMO    = 3;
  localparam int WORD_W = 16;

  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_issue = 2'b01;
  localparam logic [1:0] c_st_wait  = 2'b10;

  localparam logic [2:0] c_op_mv  = 3'b000;
  localparam logic [2:0] c_op_mvt = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;

endpackage
`default_nettype wire

// File: rtl/ififo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ififo : instruction FIFO with non-bypassing read and registered pointers
// Revision: 1.0
// ---------------------------------------------------------------------------
module ififo
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH = proc_feeder_pkg::DEPTH,
  parameter int WIDTH = proc_feeder_pkg::WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_cnt_full);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rd_data   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: empty/full depend only on the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/proc_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_feeder : queues instruction words and issues them one at a time to a
//               processor, waiting for Done or a timeout between issues
// Revision: 1.0
// ---------------------------------------------------------------------------
module proc_feeder
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH = proc_feeder_pkg::DEPTH,
  parameter int TMO   = proc_feeder_pkg::TMO
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        WrEn,
  input  logic [15:0] WrData,
  output logic        Full,
  input  logic        Enable,
  output logic [15:0] DOUT,
  output logic        Run,
  input  logic        Done,
  output logic        Busy,
  output logic        Err,
  output logic [7:0]  IssueCount
);

  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] c_tmo_last = TW'(TMO - 1);
  localparam logic [TW-1:0] c_wcnt_one = TW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [TW-1:0] r_wcnt;
  logic [15:0]   r_dout;
  logic [7:0]    r_issue_cnt;
  logic          r_err;
  logic          w_pop;
  logic          w_finish;
  logic          w_timeout;
  logic          w_fifo_empty;
  logic [15:0]   w_fifo_data;

  ififo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_ififo (
    .clk     (Clock),
    .rst     (Reset),
    .push    (WrEn),
    .wr_data (WrData),
    .pop     (w_pop),
    .rd_data (w_fifo_data),
    .full    (Full),
    .empty   (w_fifo_empty)
  );

  // Done wins over a coincident timeout so a late-but-valid completion is not flagged.
  assign w_timeout = !Done && (r_wcnt == c_tmo_last);
  assign w_finish  = (r_state == c_st_wait) && (Done || w_timeout);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (Enable && !w_fifo_empty) begin
          w_state_nxt = c_st_issue;
          w_pop       = 1'b1;
        end
      end
      c_st_issue: w_state_nxt = c_st_wait;
      c_st_wait: begin
        if (w_finish) begin
          if (Enable && !w_fifo_empty) begin
            w_state_nxt = c_st_issue;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = c_st_idle;
          end
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    Run        = (r_state == c_st_issue);
    Busy       = (r_state != c_st_idle);
    DOUT       = r_dout;
    Err        = r_err;
    IssueCount = r_issue_cnt;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_dout      <= '0;
      r_wcnt      <= '0;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      if (w_pop) r_dout <= w_fifo_data;
      if (r_state == c_st_issue)
        r_wcnt <= '0;
      else if ((r_state == c_st_wait) && !Done)
        r_wcnt <= r_wcnt + c_wcnt_one;
      if (w_finish) r_issue_cnt <= r_issue_cnt + 8'd1;
      if (w_finish && w_timeout) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_proc_feeder : scoreboard bench with a processor model and random traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_proc_feeder;

  localparam int DEPTH_T = 8;
  localparam int TMO_T   = 3;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        WrEn = 1'b0;
  logic [15:0] WrData = '0;
  logic        Enable = 1'b0;
  logic        Done = 1'b0;
  logic        Full;
  logic [15:0] DOUT;
  logic        Run;
  logic        Busy;
  logic        Err;
  logic [7:0]  IssueCount;

  proc_feeder #(.DEPTH(DEPTH_T), .TMO(TMO_T)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WrEn       (WrEn),
    .WrData     (WrData),
    .Full       (Full),
    .Enable     (Enable),
    .DOUT       (DOUT),
    .Run        (Run),
    .Done       (Done),
    .Busy       (Busy),
    .Err        (Err),
    .IssueCount (IssueCount)
  );

  initial forever #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Processor completion latency in WAIT cycles; 0 means it never answers.
  function automatic int lat_of(input logic [15:0] w);
    case (w[15:13])
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 3;
      default:    return 0;
    endcase
  endfunction

  // Processor model; Done outside WAIT is random noise that must be ignored.
  int plat = 0;
  int wk = 0;
  initial forever begin
    @(negedge Clock);
    if (Run) begin
      plat = lat_of(DOUT);
      wk   = 0;
      Done = 1'($urandom_range(0, 1));
    end else if (Busy) begin
      wk++;
      Done = (plat != 0) && (wk == plat);
    end else begin
      Done = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: queue of words expected to issue, plus completion timing.
  logic [15:0] exp_q[$];
  bit          mon_en = 0;
  int          cyc = 0;
  int          end_cyc = -1;
  bit          busy_prev = 0;
  int          occ_prev = 0;
  int          cnt_exp = 0;
  bit          err_exp = 0;
  bit          to_pend = 0;
  logic [15:0] last_w = '0;
  bit          run_exp;
  bit          busy_exp;
  int          mlat;

  initial forever begin
    @(negedge Clock);
    cyc++;
    if (mon_en) begin
      run_exp = Enable && (occ_prev > 0) && (!busy_prev || cyc == end_cyc);
      if (busy_prev && cyc == end_cyc) begin
        cnt_exp = (cnt_exp + 1) % 256;
        if (to_pend) err_exp = 1;
      end
      chk("run", 32'(Run), 32'(run_exp));
      if (run_exp && exp_q.size() > 0) begin
        last_w = exp_q.pop_front();
        chk("dout_issue", 32'(DOUT), 32'(last_w));
        mlat    = lat_of(last_w);
        end_cyc = cyc + ((mlat == 0) ? TMO_T : mlat) + 1;
        to_pend = (mlat == 0);
      end
      busy_exp = run_exp || (busy_prev && cyc < end_cyc);
      chk("busy", 32'(Busy), 32'(busy_exp));
      chk("issue_count", 32'(IssueCount), 32'(cnt_exp));
      chk("err", 32'(Err), 32'(err_exp));
      chk("full", 32'(Full), 32'(exp_q.size() == DEPTH_T));
      if (busy_exp) chk("dout_hold", 32'(DOUT), 32'(last_w));
      occ_prev  = exp_q.size();
      busy_prev = busy_exp;
    end
  end

  task automatic step(input logic we, input logic [15:0] d, input logic en);
    @(negedge Clock);
    #1;
    WrEn   = we;
    WrData = d;
    Enable = en;
    if (we && exp_q.size() < DEPTH_T) exp_q.push_back(d);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 16'h0, 1'b1);
      if (exp_q.size() == 0 && !Busy && !Run) begin
        ok = 1;
        break;
      end
    end
    chk("drain_done", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    mon_en = 0;
    Reset  = 1'b1;
    WrEn   = 1'b0;
    Enable = 1'b0;
    #1;
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_issue_count", 32'(IssueCount), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
    repeat (2) @(negedge Clock);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    end_cyc   = -1;
    busy_prev = 0;
    occ_prev  = 0;
    cnt_exp   = 0;
    err_exp   = 0;
    mon_en    = 1;
  endtask

  initial begin
    bit ok;
    do_reset();

    // single mv, single add, timeout followed by a queued mv
    step(1'b1, 16'h1005, 1'b1);
    wait_idle();
    step(1'b1, 16'h4001, 1'b1);
    wait_idle();
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h1005, 1'b0);
    wait_idle();

    // overfill with issuing blocked, then drain in order
    for (int i = 0; i < 9; i++)
      step(1'b1, (i % 2 == 1) ? 16'(16'h1000 + i) : 16'(16'h4000 + i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("full_after_9", 32'(Full), 32'd1);
    wait_idle();

    // random traffic with concurrent push and pop
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 4) != 0));
    wait_idle();

    // reset during WAIT of an add
    step(1'b1, 16'h4001, 1'b1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 1'b1);
      if (Busy && !Run) begin
        ok = 1;
        break;
      end
    end
    chk("reach_wait", 32'(ok), 32'd1);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0003, 1'b1);
    wait_idle();

    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    wait_idle();
    step(1'b0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
